// File: rtl/act_lut_loader_pkg.sv
// act_lut_loader_pkg: shared sizes, FSM encoding and range check for the LUT loader
package act_lut_loader_pkg;
  localparam int LUT_WIDTH  = 24;
  localparam int LUT_DEPTH  = 16;
  localparam int ADDR_WIDTH = 5;
  localparam int IN_WIDTH   = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FIN = 2'd2} state_t;
  // Widened by two bits so base + num never overflows before the compare.
  function automatic logic range_ok(input logic [ADDR_WIDTH-1:0] base, input logic [ADDR_WIDTH:0] num);
    return (num != '0) && (({2'b0, base} + {1'b0, num}) <= (ADDR_WIDTH+2)'(LUT_DEPTH));
  endfunction
endpackage

// File: rtl/act_lut_loader_if.sv
// act_lut_loader_if: command, entry stream, LUT write port and status bundle
//   slave  - the loader: takes i_* (command + stream), drives o_* (ready, BRAM write, status)
//   master - the feeder/observer side, the mirror image
interface act_lut_loader_if;
  import act_lut_loader_pkg::*;
  logic                  i_start;
  logic [ADDR_WIDTH-1:0] i_base_addr;
  logic [ADDR_WIDTH:0]   i_num_entries;
  logic [IN_WIDTH-1:0]   i_s_tdata;
  logic                  i_s_tvalid;
  logic                  i_s_tlast;
  logic                  o_s_tready;
  logic [23:0]           o_lut_bramctl_wdata;
  logic [ADDR_WIDTH-1:0] o_lut_bramctl_addr;
  logic                  o_lut_bramctl_we;
  logic                  o_lut_bramctl_en;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_err;
  logic                  o_lut_ready;
  modport slave (
    input  i_start, i_base_addr, i_num_entries, i_s_tdata, i_s_tvalid, i_s_tlast,
    output o_s_tready, o_lut_bramctl_wdata, o_lut_bramctl_addr, o_lut_bramctl_we,
           o_lut_bramctl_en, o_busy, o_done, o_err, o_lut_ready
  );
  modport master (
    output i_start, i_base_addr, i_num_entries, i_s_tdata, i_s_tvalid, i_s_tlast,
    input  o_s_tready, o_lut_bramctl_wdata, o_lut_bramctl_addr, o_lut_bramctl_we,
           o_lut_bramctl_en, o_busy, o_done, o_err, o_lut_ready
  );
endinterface

// File: rtl/act_lut_loader.sv
// act_lut_loader: streams LUT entries into the activation-LUT BRAM write port after a start command
//   i_clk, i_rst - clock and synchronous active-high reset
//   bus (slave)  - start/base/num command, entry stream in, tready out,
//                  registered BRAM write (wdata/addr/we/en), busy/done/err/lut_ready status
module act_lut_loader
  import act_lut_loader_pkg::*;
(
  input logic            i_clk,
  input logic            i_rst,
  act_lut_loader_if.slave bus
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_WIDTH:0]   beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH:0]   num_q, num_d;
  logic                  mismatch_q, mismatch_d;
  logic                  tready_q, tready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [23:0]           wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  lut_ready_q, lut_ready_d;
  logic                  cmd_ok, start_ok, acc, last_beat, end_load;
  always_comb begin
    cmd_ok    = range_ok(bus.i_base_addr, bus.i_num_entries);
    start_ok  = (state_q == IDLE) && bus.i_start && cmd_ok;
    acc       = (state_q == LOAD) && bus.i_s_tvalid && tready_q;
    last_beat = beat_cnt_q == (num_q - (ADDR_WIDTH+1)'(1));
    // An early tlast closes the load just like the final beat does.
    end_load  = acc && (last_beat || bus.i_s_tlast);
  end
  always_comb begin
    state_d = state_q == IDLE ? (start_ok ? LOAD : IDLE) :
              state_q == LOAD ? (end_load ? FIN : LOAD) : IDLE;
  end
  always_comb begin
    addr_cnt_d  = start_ok ? bus.i_base_addr : acc ? addr_cnt_q + ADDR_WIDTH'(1) : addr_cnt_q;
    beat_cnt_d  = start_ok ? '0 : acc ? beat_cnt_q + (ADDR_WIDTH+1)'(1) : beat_cnt_q;
    num_d       = start_ok ? bus.i_num_entries : num_q;
    mismatch_d  = end_load ? !(last_beat && bus.i_s_tlast) : mismatch_q;
    tready_d    = state_d == LOAD;
    we_d        = acc;
    addr_d      = acc ? addr_cnt_q : addr_q;
    wdata_d     = acc ? 24'(bus.i_s_tdata[LUT_WIDTH-1:0]) : wdata_q;
    busy_d      = state_d != IDLE;
    done_d      = state_q == FIN;
    err_d       = (state_q == FIN && mismatch_q) || (state_q == IDLE && bus.i_start && !cmd_ok);
    lut_ready_d = state_q == FIN ? !mismatch_q : start_ok ? 1'b0 : lut_ready_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      addr_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      num_q       <= '0;
      mismatch_q  <= 1'b0;
      tready_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      lut_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      num_q       <= num_d;
      mismatch_q  <= mismatch_d;
      tready_q    <= tready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      lut_ready_q <= lut_ready_d;
    end
  end
  assign bus.o_s_tready          = tready_q;
  assign bus.o_lut_bramctl_we    = we_q;
  assign bus.o_lut_bramctl_en    = we_q;
  assign bus.o_lut_bramctl_addr  = addr_q;
  assign bus.o_lut_bramctl_wdata = wdata_q;
  assign bus.o_busy              = busy_q;
  assign bus.o_done              = done_q;
  assign bus.o_err               = err_q;
  assign bus.o_lut_ready         = lut_ready_q;
endmodule
